lq_replay_sched: RTL

//  Replay scheduler for the load queue. Tracks, per LQ entry, whether a load that missed
//  in dcache (or was nacked for MSHR-full) is waiting for refill or ready to re-issue.

---
 rtl/lq_replay_sched_pkg.sv | 25 ++
 rtl/age_prio_sel.sv | 32 +++
 rtl/lq_replay_sched.sv | 135 +++++++++++++
 3 files changed

// File: rtl/lq_replay_sched_pkg.sv
// rtl/lq_replay_sched_pkg.sv - shared types and helpers for the load-queue replay scheduler
package lq_replay_sched_pkg;

  localparam int MSHR_NUM = 4;
  localparam int MSHR_W   = $clog2(MSHR_NUM);
  localparam int CNT_MAX  = 64;

  typedef logic [MSHR_W-1:0] mshrIdx_t;

  typedef enum logic [2:0] {
    LRS_IDLE,
    LRS_WAIT,
    LRS_WAIT_ANY,
    LRS_READY,
    LRS_ISSUED
  } lqReplayState_t;

  function automatic logic [6:0] count_one(input logic [CNT_MAX-1:0] v);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < CNT_MAX; i++) c = c + {6'd0, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/age_prio_sel.sv
// rtl/age_prio_sel.sv - circular priority select: first request at/after a base index
module age_prio_sel #(
  parameter int DEPTH = 32
) (
  input  logic [DEPTH-1:0]         req_i,
  input  logic [$clog2(DEPTH)-1:0] base_i,
  output logic [DEPTH-1:0]         onehot_o,
  output logic [$clog2(DEPTH)-1:0] idx_o,
  output logic                     vld_o
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [2*DEPTH-1:0] dbl;
  logic [DEPTH-1:0]   rot;
  logic [IDX_W-1:0]   pe;

  always_comb begin
    dbl = {req_i, req_i};
    // rot[j] corresponds to entry (base + j) mod DEPTH
    rot = dbl[base_i +: DEPTH];
    pe  = '0;
    for (int j = DEPTH - 1; j >= 0; j--) begin
      if (rot[j]) pe = IDX_W'(j);
    end
    vld_o    = |rot;
    idx_o    = pe + base_i;
    onehot_o = '0;
    if (vld_o) onehot_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/lq_replay_sched.sv
// rtl/lq_replay_sched.sv - per-entry miss/refill tracking and oldest-first replay issue
module lq_replay_sched
  import lq_replay_sched_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_flush,
  input  logic [$clog2(DEPTH):0]   i_deq_ptr,
  input  logic                     i_miss_vld,
  input  logic [$clog2(DEPTH):0]   i_miss_lqIdx,
  input  logic                     i_miss_nack,
  input  mshrIdx_t                 i_miss_mshr,
  input  logic                     i_hit_vld,
  input  logic [$clog2(DEPTH):0]   i_hit_lqIdx,
  input  logic                     i_refill_vld,
  input  mshrIdx_t                 i_refill_mshr,
  input  logic [DEPTH-1:0]         i_free_vec,
  output logic                     o_replay_vld,
  output logic [$clog2(DEPTH):0]   o_replay_lqIdx,
  input  logic                     i_replay_rdy,
  output logic [$clog2(DEPTH):0]   o_waiting_num
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  lqReplayState_t state_q [DEPTH];
  lqReplayState_t state_d [DEPTH];
  mshrIdx_t       mshr_q  [DEPTH];
  mshrIdx_t       mshr_d  [DEPTH];

  logic             out_vld_q, out_vld_d;
  logic [IDX_W:0]   out_idx_q, out_idx_d;
  logic [CNT_W-1:0] wait_num_q, wait_num_d;

  logic [DEPTH-1:0]   req;
  logic [DEPTH-1:0]   sel_oh;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_vld;
  logic               held_freed;
  logic               load;
  logic               sel_flip;
  logic [CNT_MAX-1:0] busy_vec;
  logic               unused_flip_bits;

  assign unused_flip_bits = ^{i_miss_lqIdx[IDX_W], i_hit_lqIdx[IDX_W]};

  // Entries being freed this cycle must not enter the output register
  always_comb begin
    for (int i = 0; i < DEPTH; i++) req[i] = (state_q[i] == LRS_READY) && !i_free_vec[i];
  end

  age_prio_sel #(.DEPTH(DEPTH)) u_age_prio_sel (
    .req_i    (req),
    .base_i   (i_deq_ptr[IDX_W-1:0]),
    .onehot_o (sel_oh),
    .idx_o    (sel_idx),
    .vld_o    (sel_vld)
  );

  assign sel_flip   = i_deq_ptr[IDX_W] ^ (sel_idx < i_deq_ptr[IDX_W-1:0]);
  assign held_freed = out_vld_q && i_free_vec[out_idx_q[IDX_W-1:0]];
  assign load       = !held_freed && (!out_vld_q || i_replay_rdy);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      state_d[i] = state_q[i];
      mshr_d[i]  = mshr_q[i];
      unique case (state_q[i])
        LRS_IDLE, LRS_ISSUED: begin
          if (i_miss_vld && i_miss_lqIdx[IDX_W-1:0] == IDX_W'(i)) begin
            if (i_miss_nack) begin
              state_d[i] = i_refill_vld ? LRS_READY : LRS_WAIT_ANY;
            end else begin
              mshr_d[i]  = i_miss_mshr;
              state_d[i] = (i_refill_vld && i_refill_mshr == i_miss_mshr) ? LRS_READY : LRS_WAIT;
            end
          end else if (state_q[i] == LRS_ISSUED && i_hit_vld &&
                       i_hit_lqIdx[IDX_W-1:0] == IDX_W'(i)) begin
            state_d[i] = LRS_IDLE;
          end
        end
        LRS_WAIT:     if (i_refill_vld && i_refill_mshr == mshr_q[i]) state_d[i] = LRS_READY;
        LRS_WAIT_ANY: if (i_refill_vld) state_d[i] = LRS_READY;
        LRS_READY:    if (load && sel_oh[i]) state_d[i] = LRS_ISSUED;
        default:      state_d[i] = LRS_IDLE;
      endcase
      if (i_free_vec[i]) state_d[i] = LRS_IDLE;
    end
  end

  always_comb begin
    out_vld_d = out_vld_q;
    out_idx_d = out_idx_q;
    if (held_freed) begin
      out_vld_d = 1'b0;
    end else if (load) begin
      out_vld_d = sel_vld;
      if (sel_vld) out_idx_d = {sel_flip, sel_idx};
    end
  end

  always_comb begin
    busy_vec = '0;
    for (int i = 0; i < DEPTH; i++) busy_vec[i] = (state_d[i] != LRS_IDLE);
    wait_num_d = CNT_W'(count_one(busy_vec));
  end

  always_ff @(posedge clk) begin
    if (!rst || i_flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= LRS_IDLE;
        mshr_q[i]  <= '0;
      end
      out_vld_q  <= 1'b0;
      out_idx_q  <= '0;
      wait_num_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= state_d[i];
        mshr_q[i]  <= mshr_d[i];
      end
      out_vld_q  <= out_vld_d;
      out_idx_q  <= out_idx_d;
      wait_num_q <= wait_num_d;
    end
  end

  assign o_replay_vld   = out_vld_q;
  assign o_replay_lqIdx = out_idx_q;
  assign o_waiting_num  = wait_num_q;

endmodule
